pushbutton_alu: RTL and testbench
=================================

PUSHBUTTON_ALU -- requirements
Module: pushbutton_alu

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, operand and result width in bits (legal 1..32).
REQ-002 SHALL provide parameter SYNC_STAGES, default 2, pushbutton synchronizer depth (legal 2..4).
REQ-003 SHALL provide port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL provide port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL provide port left_pushbutton, input, 1, asynchronous button; rising edge selects AND.
REQ-006 SHALL provide port right_pushbutton, input, 1, asynchronous button; rising edge selects ADD.
REQ-007 SHALL provide port A, input, WIDTH, operand A.
REQ-008 SHALL provide port B, input, WIDTH, operand B.
REQ-009 SHALL provide port in_valid, input, 1, operands valid this cycle.
REQ-010 SHALL provide port out, output, WIDTH, registered result.
REQ-011 SHALL provide port carry, output, 1, registered ADD carry-out.
REQ-012 SHALL provide port out_valid, output, 1, one-cycle pulse marking a new result.
REQ-013 SHALL provide port mode, output, 2, current operation register.

Function
REQ-014 SHALL pass each button through a SYNC_STAGES-flop synchronizer, then a one-flop edge detector (sync output high, previous sample low).
REQ-015 SHALL update mode on the cycle after a detected edge: left only -> MODE_AND; right only -> MODE_ADD; both same cycle -> MODE_XOR.
REQ-016 SHALL hold mode when no edge is detected; a held button produces exactly one edge.
REQ-017 SHALL have button-to-mode latency of SYNC_STAGES+1 cycles from the first clk edge sampling the button high.
REQ-018 SHALL, when in_valid=1, register out = f(mode, A, B) using the mode value present in that cycle (a mode change in the same cycle applies to the next operation).
REQ-019 SHALL compute AND as A&B, ADD as (A+B) mod 2^WIDTH with carry = bit WIDTH of the sum, XOR as A^B; carry=0 for AND/XOR.
REQ-020 SHALL assert out_valid exactly one cycle after each in_valid=1 cycle; back-to-back in_valid gives back-to-back out_valid.
REQ-021 SHALL hold out and carry unchanged when in_valid=0.
REQ-022 SHALL never encode mode 2'b11; if reached, it SHALL be treated as MODE_AND for the operation and corrected to MODE_AND next cycle.

Reset
REQ-023 SHALL, while reset=1, force mode=MODE_AND, out=0, carry=0, out_valid=0, and all synchronizer and edge flops to 0, independent of clk.
REQ-024 SHALL discard any operation in flight when reset asserts; no out_valid follows reset release unless in_valid=1 after release.
REQ-025 SHALL treat a button held through reset release as one new press, registering SYNC_STAGES+1 cycles after the first clk edge following release.

Structure
REQ-026 SHALL place MODE_AND=2'd0, MODE_ADD=2'd1, MODE_XOR=2'd2 in a shared package pushbutton_alu_pkg.
REQ-027 SHALL implement synchronizer plus edge detector as sub-module button_edge_sync (parameter SYNC_STAGES), instantiated once per button.
REQ-028 SHALL contain no latches and no combinational path from A, B or buttons to any output.

Verification (WIDTH=4, SYNC_STAGES=2)
REQ-029 SHALL cover: reset, in_valid=1, A=4'b1100, B=4'b1010 -> next cycle out=4'b1000, carry=0, out_valid=1.
REQ-030 SHALL cover: right press, wait 3 cycles, A=4'b1100, B=4'b1010 -> out=4'b0110, carry=1, mode=1.
REQ-031 SHALL cover: ADD mode, A=4'b0001, B=4'b0011, then A=4'b1111, B=4'b0001 back-to-back -> out=4'b0100 carry=0, then out=4'b0000 carry=1, out_valid high two cycles.
REQ-032 SHALL cover: both buttons rise same cycle -> mode=2 after 3 cycles; A=4'b0001, B=4'b0011 -> out=4'b0010.
REQ-033 SHALL cover: left button held 20 cycles, in ADD mode -> exactly one mode change to 0; release and no press -> mode stays 0.
REQ-034 SHALL cover: reset asserted mid-stream between clk edges with in_valid=1 -> out=0, out_valid=0, mode=0 immediately; held right button -> mode=1 three cycles after release.

Source files
------------

// File: rtl/pushbutton_alu_pkg.sv
// -----------------------------------------------------------------------------
// pushbutton_alu_pkg
//   Shared definitions for the pushbutton ALU: the operation-mode encoding and
//   the mode-selection rule applied when synchronized button edges arrive.
//
//   Contents:
//     MODE_W        width of the mode register
//     mode_t        MODE_AND=0, MODE_ADD=1, MODE_XOR=2 (2'b11 is never encoded)
//     select_mode   next mode from the current mode and the two edge pulses
// -----------------------------------------------------------------------------
package pushbutton_alu_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_AND = 2'd0,
        MODE_ADD = 2'd1,
        MODE_XOR = 2'd2
    } mode_t;

    // Both buttons rising on the same cycle selects XOR; a single edge selects
    // that button's operation; no edge holds the current mode. An unencoded
    // current value is folded back to AND so the register self-corrects.
    function automatic mode_t select_mode(input mode_t cur,
                                          input logic  left_rise,
                                          input logic  right_rise);
        mode_t held;
        case (cur)
            MODE_AND, MODE_ADD, MODE_XOR: held = cur;
            default:                      held = MODE_AND;
        endcase

        if (left_rise && right_rise) begin
            return MODE_XOR;
        end else if (left_rise) begin
            return MODE_AND;
        end else if (right_rise) begin
            return MODE_ADD;
        end
        return held;
    endfunction

endpackage

// File: rtl/pushbutton_alu_button_sync.sv
// -----------------------------------------------------------------------------
// button_edge_sync
//   Brings one asynchronous pushbutton into the clk domain through a chain of
//   SYNC_STAGES flops, then flags the first cycle the synchronized level is
//   high after having been low.
//
//   Ports:
//     clk     rising-edge clock
//     reset   asynchronous active-high reset; clears the chain and edge flop
//     button  raw asynchronous button level
//     rise    one-cycle pulse per low-to-high transition of the synced level
// -----------------------------------------------------------------------------
module button_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], button};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    // Decoded from flops only, so the raw button never reaches logic
    // combinationally. Clearing prev in reset makes a button held through
    // reset release look like a fresh press.
    assign rise = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/pushbutton_alu.sv
// -----------------------------------------------------------------------------
// pushbutton_alu
//   Small registered ALU whose operation is chosen by two pushbuttons:
//   left selects AND, right selects ADD, both on the same cycle select XOR.
//   Each in_valid cycle produces one registered result one cycle later.
//
//   Parameters:
//     WIDTH        operand/result width (1..32)
//     SYNC_STAGES  button synchronizer depth (2..4)
//
//   Ports:
//     clk               rising-edge clock
//     reset             asynchronous active-high reset
//     left_pushbutton   async button, rising edge selects AND
//     right_pushbutton  async button, rising edge selects ADD
//     A, B              operands
//     in_valid          operands valid this cycle
//     out               registered result
//     carry             registered ADD carry-out (0 for AND/XOR)
//     out_valid         one-cycle pulse marking a new result
//     mode              current operation register
// -----------------------------------------------------------------------------
module pushbutton_alu
    import pushbutton_alu_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              left_pushbutton,
    input  logic              right_pushbutton,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    input  logic              in_valid,
    output logic [WIDTH-1:0]  out,
    output logic              carry,
    output logic              out_valid,
    output logic [MODE_W-1:0] mode
);

    logic  left_rise;
    logic  right_rise;
    mode_t mode_q;
    mode_t mode_next;
    logic [WIDTH:0] result;

    // Carry rides in the top bit; only ADD can set it. Any unencoded mode
    // value falls through to AND.
    function automatic logic [WIDTH:0] alu_eval(input mode_t            m,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [WIDTH:0] r;
        case (m)
            MODE_ADD: r = {1'b0, a} + {1'b0, b};
            MODE_XOR: r = {1'b0, a ^ b};
            default:  r = {1'b0, a & b};
        endcase
        return r;
    endfunction

    button_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_left_sync (
        .clk    (clk),
        .reset  (reset),
        .button (left_pushbutton),
        .rise   (left_rise)
    );

    button_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_right_sync (
        .clk    (clk),
        .reset  (reset),
        .button (right_pushbutton),
        .rise   (right_rise)
    );

    always_comb begin
        mode_next = mode_q;
        mode_next = select_mode(mode_q, left_rise, right_rise);
    end

    // The operation uses mode_q, i.e. the mode before any update landing on
    // the same edge, so a press never retroactively changes an operation.
    always_comb begin
        result = '0;
        result = alu_eval(mode_q, A, B);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= MODE_AND;
        end else begin
            mode_q <= mode_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out       <= '0;
            carry     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out   <= result[WIDTH-1:0];
                carry <= result[WIDTH];
            end
        end
    end

    assign mode = mode_q;

endmodule

// File: tb/tb_pushbutton_alu.sv
module tb_pushbutton_alu;
    import pushbutton_alu_pkg::*;

    localparam int WIDTH       = 4;
    localparam int SYNC_STAGES = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             left_pushbutton;
    logic             right_pushbutton;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             in_valid;
    logic [WIDTH-1:0] out;
    logic             carry;
    logic             out_valid;
    logic [1:0]       mode;

    typedef struct packed {
        logic [WIDTH-1:0] out;
        logic             carry;
    } res_t;

    res_t             sb[$];
    int               n_cmp = 0;
    int               n_bad = 0;
    logic [1:0]       mode_model;
    logic [WIDTH-1:0] last_out;
    logic             last_carry;

    always #5 clk = ~clk;

    pushbutton_alu #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .left_pushbutton  (left_pushbutton),
        .right_pushbutton (right_pushbutton),
        .A                (A),
        .B                (B),
        .in_valid         (in_valid),
        .out              (out),
        .carry            (carry),
        .out_valid        (out_valid),
        .mode             (mode)
    );

    function automatic res_t model(input logic [1:0] m,
                                   input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b);
        res_t           r;
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        case (m)
            2'd1: begin r.out = s[WIDTH-1:0]; r.carry = s[WIDTH]; end
            2'd2: begin r.out = a ^ b;        r.carry = 1'b0;     end
            default: begin r.out = a & b;     r.carry = 1'b0;     end
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance past the edge, check the result slot.
    task automatic cycle(input logic iv, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        res_t e;
        A        = a;
        B        = b;
        in_valid = iv;
        if (iv) sb.push_back(model(mode_model, a, b));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("out_valid", {31'd0, out_valid}, {31'd0, iv});
        if (iv) begin
            chk("sb_has_entry", sb.size(), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("out", {28'd0, out}, {28'd0, e.out});
                chk("carry", {31'd0, carry}, {31'd0, e.carry});
                last_out   = e.out;
                last_carry = e.carry;
            end
        end else begin
            chk("out_hold", {28'd0, out}, {28'd0, last_out});
            chk("carry_hold", {31'd0, carry}, {31'd0, last_carry});
        end
    endtask

    // Press buttons and verify mode is unchanged for SYNC_STAGES edges and
    // updates on the following one.
    task automatic press(input logic l, input logic r, input logic [1:0] newm);
        left_pushbutton  = l;
        right_pushbutton = r;
        for (int i = 0; i < SYNC_STAGES; i++) begin
            cycle(1'b0, '0, '0);
            chk("mode_pre", {30'd0, mode}, {30'd0, mode_model});
        end
        cycle(1'b0, '0, '0);
        mode_model = newm;
        chk("mode_post", {30'd0, mode}, {30'd0, mode_model});
        left_pushbutton  = 1'b0;
        right_pushbutton = 1'b0;
    endtask

    initial begin
        int         changes;
        logic [1:0] prev_mode;

        reset            = 1'b1;
        left_pushbutton  = 1'b0;
        right_pushbutton = 1'b0;
        A                = '0;
        B                = '0;
        in_valid         = 1'b0;
        mode_model       = 2'd0;
        last_out         = '0;
        last_carry       = 1'b0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_out", {28'd0, out}, 32'd0);
        chk("rst_carry", {31'd0, carry}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mode", {30'd0, mode}, 32'd0);
        reset = 1'b0;

        // AND after reset
        cycle(1'b1, 4'b1100, 4'b1010);
        cycle(1'b0, 4'b1111, 4'b1111);

        // Right press -> ADD
        press(1'b0, 1'b1, 2'd1);
        cycle(1'b1, 4'b1100, 4'b1010);

        // Back-to-back ADD with and without carry
        cycle(1'b1, 4'b0001, 4'b0011);
        cycle(1'b1, 4'b1111, 4'b0001);
        cycle(1'b0, 4'b0000, 4'b0000);

        // Both buttons same cycle -> XOR
        press(1'b1, 1'b1, 2'd2);
        cycle(1'b1, 4'b0001, 4'b0011);
        cycle(1'b1, 4'b1111, 4'b1010);

        // Back to ADD, then hold left for 20 cycles
        press(1'b0, 1'b1, 2'd1);
        left_pushbutton = 1'b1;
        changes   = 0;
        prev_mode = mode;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, '0, '0);
            if (i == SYNC_STAGES) mode_model = 2'd0;
            chk("held_mode", {30'd0, mode}, {30'd0, mode_model});
            if (mode !== prev_mode) changes++;
            prev_mode = mode;
        end
        chk("held_changes", changes, 32'd1);
        left_pushbutton = 1'b0;
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, '0);
        chk("released_mode", {30'd0, mode}, 32'd0);
        cycle(1'b1, 4'b1111, 4'b0101);

        // Operation on the same edge as a mode change uses the old mode
        right_pushbutton = 1'b1;
        cycle(1'b0, '0, '0);
        cycle(1'b0, '0, '0);
        chk("mode_before_switch", {30'd0, mode}, 32'd0);
        cycle(1'b1, 4'b1100, 4'b1010);
        mode_model = 2'd1;
        chk("mode_after_switch", {30'd0, mode}, 32'd1);
        right_pushbutton = 1'b0;
        cycle(1'b1, 4'b1100, 4'b1010);

        // Asynchronous reset mid-stream with an operation in flight
        cycle(1'b1, 4'b0111, 4'b0110);
        A                = 4'b1010;
        B                = 4'b0101;
        in_valid         = 1'b1;
        right_pushbutton = 1'b1;
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_out", {28'd0, out}, 32'd0);
        chk("async_rst_carry", {31'd0, carry}, 32'd0);
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_mode", {30'd0, mode}, 32'd0);
        sb.delete();
        mode_model = 2'd0;
        last_out   = '0;
        last_carry = 1'b0;
        in_valid   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        // Button held through release counts as one new press
        press(1'b0, 1'b1, 2'd1);
        cycle(1'b0, '0, '0);
        chk("post_rst_mode", {30'd0, mode}, 32'd1);
        chk("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
